// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline boundary stage for the 64-bit datapath.
//
// This stage does three things:
//   - Registers the ALU result, the store data, the destination register and the
//     memory/writeback control bits into the EX/MEM pipeline register.
//   - Holds the architectural NZCV flag register. Only flag-setting instructions
//     (ADDS/SUBS) update it.
//   - Resolves B, CBZ and B.cond during the EX cycle. It then registers a
//     one-cycle branch-taken pulse and the branch target for the fetch stage.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall, flush        hold the whole stage, or load a bubble
//   in_valid            EX instruction valid
//   alu_*               ALU result and flags (N, Z, V, C)
//   set_flags           instruction writes NZCV
//   br_type, cond       00 none, 01 B, 10 CBZ, 11 B.cond; condition code for B.cond
//   br_target           computed branch target
//   store_data, rd      STUR data and destination register index
//   reg_write, mem_read, mem_write   control bits for later stages
//   mem_*               registered EX/MEM entry
//   flags_nzcv          architectural flags {N,Z,C,V}
//   br_taken            registered taken pulse; br_target_q is valid while it is set
module ex_mem_flag_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              set_flags,
  input  logic [1:0]        br_type,
  input  logic [3:0]        cond,
  input  logic [DATA_W-1:0] br_target,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [3:0]        flags_nzcv,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target_q
);

  localparam logic [1:0] BrNone = 2'b00;
  localparam logic [1:0] BrUncond = 2'b01;
  localparam logic [1:0] BrCbz = 2'b10;
  localparam logic [1:0] BrCond = 2'b11;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_true;
  logic br_hit;

  // B.cond reads the committed flags, which are the value before this edge.
  // An older flag-setter has already written them at its own EX edge, so no
  // bypass path is needed.
  assign flag_n = flags_nzcv[3];
  assign flag_z = flags_nzcv[2];
  assign flag_c = flags_nzcv[1];
  assign flag_v = flags_nzcv[0];

  always_comb begin
    cond_true = 1'b1;
    unique case (cond)
      4'h0: cond_true = flag_z;
      4'h1: cond_true = !flag_z;
      4'h2: cond_true = flag_c;
      4'h3: cond_true = !flag_c;
      4'h4: cond_true = flag_n;
      4'h5: cond_true = !flag_n;
      4'h6: cond_true = flag_v;
      4'h7: cond_true = !flag_v;
      4'h8: cond_true = flag_c && !flag_z;
      4'h9: cond_true = !flag_c || flag_z;
      4'hA: cond_true = (flag_n == flag_v);
      4'hB: cond_true = (flag_n != flag_v);
      4'hC: cond_true = !flag_z && (flag_n == flag_v);
      4'hD: cond_true = flag_z || (flag_n != flag_v);
      default: cond_true = 1'b1;  // AL and NV both mean "always"
    endcase
  end

  // CBZ relies on the ALU passing Rt through, so alu_zero means "Rt == 0".
  always_comb begin
    br_hit = 1'b0;
    unique case (br_type)
      BrNone:   br_hit = 1'b0;
      BrUncond: br_hit = 1'b1;
      BrCbz:    br_hit = alu_zero;
      BrCond:   br_hit = cond_true;
      default:  br_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      flags_nzcv     <= 4'b0000;
      br_taken       <= 1'b0;
      br_target_q    <= '0;
    end else if (!stall) begin
      if (flush) begin
        // Bubble: the data fields are don't-care, so they simply hold.
        mem_valid     <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_mem_read  <= 1'b0;
        mem_mem_write <= 1'b0;
        br_taken      <= 1'b0;
      end else begin
        mem_valid      <= in_valid;
        mem_alu_result <= alu_result;
        mem_store_data <= store_data;
        mem_rd         <= rd;
        mem_reg_write  <= in_valid && reg_write;
        mem_mem_read   <= in_valid && mem_read;
        mem_mem_write  <= in_valid && mem_write;
        br_taken       <= in_valid && br_hit;
        br_target_q    <= br_target;
        if (in_valid && set_flags) begin
          flags_nzcv <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Scoreboard bench for ex_mem_flag_stage. Each applied stimulus pushes the
// expected post-edge state, computed by an architectural model, into a queue.
// A monitor pops one entry after every rising edge and compares it with the DUT.
module tb_ex_mem_flag_stage;

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 5;

  typedef struct {
    bit          reset, stall, flush, in_valid;
    bit [DW-1:0] alu_result;
    bit          n, z, c, v, set_flags;
    bit [1:0]    br_type;
    bit [3:0]    cond;
    bit [DW-1:0] br_target, store_data;
    bit [RW-1:0] rd;
    bit          reg_write, mem_read, mem_write;
  } stim_t;

  typedef struct {
    bit          valid;
    bit [DW-1:0] alu_result, store_data;
    bit [RW-1:0] rd;
    bit          reg_write, mem_read, mem_write;
    bit [3:0]    nzcv;
    bit          taken;
    bit [DW-1:0] target;
  } exp_t;

  logic clk = 1'b0;
  logic reset, stall, flush, in_valid;
  logic [DW-1:0] alu_result, br_target, store_data;
  logic alu_negative, alu_zero, alu_overflow, alu_carry_out, set_flags;
  logic [1:0] br_type;
  logic [3:0] cond;
  logic [RW-1:0] rd;
  logic reg_write, mem_read, mem_write;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, br_taken;
  logic [DW-1:0] mem_alu_result, mem_store_data, br_target_q;
  logic [RW-1:0] mem_rd;
  logic [3:0] flags_nzcv;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  exp_t model;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ex_mem_flag_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .set_flags(set_flags),
    .br_type(br_type), .cond(cond), .br_target(br_target), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .flags_nzcv(flags_nzcv), .br_taken(br_taken), .br_target_q(br_target_q)
  );

  // Architectural condition evaluation, using signed-compare semantics.
  function automatic bit cond_holds(input bit [3:0] cc, input bit [3:0] f);
    bit n, z, c, v, ge;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    ge = (n == v);  // signed "greater or equal" after a compare
    case (cc)
      4'h0: return z;          4'h1: return !z;
      4'h2: return c;          4'h3: return !c;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return c && !z;    4'h9: return !(c && !z);
      4'hA: return ge;         4'hB: return !ge;
      4'hC: return ge && !z;   4'hD: return !(ge && !z);
      default: return 1'b1;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.reset = ($urandom_range(0, 39) == 0);
    s.stall = ($urandom_range(0, 5) == 0);
    s.flush = ($urandom_range(0, 5) == 0);
    s.in_valid = ($urandom_range(0, 3) != 0);
    s.alu_result = {$urandom, $urandom};
    s.n = 1'($urandom); s.z = 1'($urandom); s.c = 1'($urandom); s.v = 1'($urandom);
    s.set_flags = 1'($urandom);
    s.br_type = 2'($urandom);
    s.cond = 4'($urandom);
    s.br_target = {$urandom, $urandom};
    s.store_data = {$urandom, $urandom};
    s.rd = 5'($urandom);
    s.reg_write = 1'($urandom); s.mem_read = 1'($urandom); s.mem_write = 1'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t nx;
    bit take;
    @(negedge clk);
    reset = s.reset; stall = s.stall; flush = s.flush; in_valid = s.in_valid;
    alu_result = s.alu_result; alu_negative = s.n; alu_zero = s.z;
    alu_carry_out = s.c; alu_overflow = s.v; set_flags = s.set_flags;
    br_type = s.br_type; cond = s.cond; br_target = s.br_target;
    store_data = s.store_data; rd = s.rd; reg_write = s.reg_write;
    mem_read = s.mem_read; mem_write = s.mem_write;
    nx = model;
    if (s.reset) begin
      nx = '{default: '0};
    end else if (s.stall) begin
      nx = model;
    end else if (s.flush) begin
      nx.valid = 0; nx.reg_write = 0; nx.mem_read = 0; nx.mem_write = 0; nx.taken = 0;
    end else begin
      take = (s.br_type == 2'd1) || (s.br_type == 2'd2 && s.z) ||
             (s.br_type == 2'd3 && cond_holds(s.cond, model.nzcv));
      nx.valid = s.in_valid;
      nx.alu_result = s.alu_result;
      nx.store_data = s.store_data;
      nx.rd = s.rd;
      nx.reg_write = s.in_valid && s.reg_write;
      nx.mem_read = s.in_valid && s.mem_read;
      nx.mem_write = s.in_valid && s.mem_write;
      nx.taken = s.in_valid && take;
      nx.target = s.br_target;
      if (s.in_valid && s.set_flags) nx.nzcv = {s.n, s.z, s.c, s.v};
    end
    model = nx;
    exp_q.push_back(nx);
  endtask

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  // Monitor: the stage presents a new entry after every edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mem_valid", 64'(mem_valid), 64'(e.valid));
      check("mem_alu_result", mem_alu_result, e.alu_result);
      check("mem_store_data", mem_store_data, e.store_data);
      check("mem_rd", 64'(mem_rd), 64'(e.rd));
      check("mem_reg_write", 64'(mem_reg_write), 64'(e.reg_write));
      check("mem_mem_read", 64'(mem_mem_read), 64'(e.mem_read));
      check("mem_mem_write", 64'(mem_mem_write), 64'(e.mem_write));
      check("flags_nzcv", 64'(flags_nzcv), 64'(e.nzcv));
      check("br_taken", 64'(br_taken), 64'(e.taken));
      if (e.taken) check("br_target_q", br_target_q, e.target);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    model = '{default: '0};
    reset = 1; stall = 0; flush = 0; in_valid = 0; alu_result = '0;
    alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
    set_flags = 0; br_type = 0; cond = 0; br_target = '0; store_data = '0;
    rd = '0; reg_write = 0; mem_read = 0; mem_write = 0;

    // Reset wins over a live flag-setting instruction.
    s = idle(); s.reset = 1; s.in_valid = 1; s.set_flags = 1; s.reg_write = 1;
    s.n = 1; s.z = 1; s.alu_result = 64'h1234; apply(s);

    // SUBS producing -5: expect flags 1000.
    s = idle(); s.in_valid = 1; s.set_flags = 1; s.reg_write = 1; s.rd = 5'd3;
    s.alu_result = 64'hFFFF_FFFF_FFFF_FFFB; s.n = 1; apply(s);
    // B.GE is not taken (N!=V).
    s = idle(); s.in_valid = 1; s.br_type = 2'b11; s.cond = 4'hA;
    s.br_target = 64'h0000_0000_0000_4000; apply(s);
    // B.LT is taken.
    s.cond = 4'hB; s.br_target = 64'h0000_0000_0000_5008; apply(s);
    // CBZ taken, then not taken. The flags hold.
    s = idle(); s.in_valid = 1; s.br_type = 2'b10; s.z = 1; s.br_target = 64'hAA0; apply(s);
    s.z = 0; apply(s);
    // Set-flags and B.cond in one instruction use the old flags (EQ with Z=0).
    s = idle(); s.in_valid = 1; s.set_flags = 1; s.z = 1; s.br_type = 2'b11;
    s.cond = 4'h0; apply(s);
    // Stall for three cycles with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.reset = 0; s.stall = 1; s.in_valid = 1; s.set_flags = 1;
      apply(s);
    end
    s = rand_stim(); s.reset = 0; s.stall = 0; s.flush = 0; apply(s);
    // Flush inserts a bubble and suppresses the flag update.
    s = idle(); s.in_valid = 1; s.mem_write = 1; s.br_type = 2'b01; s.set_flags = 1;
    s.n = 1; s.c = 1; s.flush = 1; apply(s);
    // Stall has priority over flush.
    s = idle(); s.in_valid = 1; s.mem_write = 1; s.br_type = 2'b01; s.alu_result = 64'h77;
    apply(s);
    s.flush = 1; s.stall = 1; s.set_flags = 1; s.z = 1; apply(s);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) apply(rand_stim());

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
